// File: rtl/avalon_timer_pkg.sv
// Shared definitions for the Avalon multi-channel timer.
// Register map per channel (byte address = {channel, index, 2'b00}):
//   index 0 CTRL   : bit0 EN, bit1 PERIODIC, bit2 IRQ_EN, bits[8 +: PSC_W] PSC
//   index 1 LOAD   : reload value
//   index 2 COUNT  : current count (read-only)
//   index 3 STATUS : bit0 PEND (write 1 to clear)
package avalon_timer_pkg;

  // Channel field is always 4 bits wide so that addresses of channels beyond
  // N_CH decode as unmapped instead of aliasing onto implemented channels.
  localparam int CH_BITS = 4;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_LOAD   = 2'd1;
  localparam logic [1:0] REG_COUNT  = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  localparam int CTRL_EN_BIT       = 0;
  localparam int CTRL_PERIODIC_BIT = 1;
  localparam int CTRL_IRQ_EN_BIT   = 2;
  localparam int CTRL_PSC_LSB      = 8;

  typedef enum logic {
    ONESHOT  = 1'b0,
    PERIODIC = 1'b1
  } mode_e;

endpackage

// File: rtl/timer_channel.sv
// One timer channel: CTRL/LOAD registers, prescaler, down-counter and PEND.
// Ports:
//   clk, rst           : clock, asynchronous active-high reset
//   wr_ctrl/load/status: single-cycle write strobes for this channel
//   wdata              : bus write data
//   ctrl_rd .. status_rd: zero-extended register read values
//   irq_req            : PEND & IRQ_EN
module timer_channel
  import avalon_timer_pkg::*;
#(
  parameter int CNT_W = 32,
  parameter int PSC_W = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_ctrl,
  input  logic        wr_load,
  input  logic        wr_status,
  input  logic [31:0] wdata,
  output logic [31:0] ctrl_rd,
  output logic [31:0] load_rd,
  output logic [31:0] count_rd,
  output logic [31:0] status_rd,
  output logic        irq_req
);

  logic             en;
  logic             irq_en;
  mode_e            mode;
  logic [PSC_W-1:0] psc;
  logic [PSC_W-1:0] psc_cnt;
  logic [CNT_W-1:0] load;
  logic [CNT_W-1:0] count;
  logic             pend;
  logic             tick;
  logic             expire;
  logic             unused_wdata;

  // >= rather than == keeps ticking sane if PSC is lowered mid-run.
  assign tick         = en && (psc_cnt >= psc);
  assign expire       = tick && (count == '0);
  assign unused_wdata = ^wdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en      <= 1'b0;
      irq_en  <= 1'b0;
      mode    <= ONESHOT;
      psc     <= '0;
      psc_cnt <= '0;
      load    <= '0;
      count   <= '0;
      pend    <= 1'b0;
    end else begin
      // A CTRL write overrides the one-shot self-disable in the same cycle.
      if (wr_ctrl) begin
        en     <= wdata[CTRL_EN_BIT];
        mode   <= mode_e'(wdata[CTRL_PERIODIC_BIT]);
        irq_en <= wdata[CTRL_IRQ_EN_BIT];
        psc    <= wdata[CTRL_PSC_LSB +: PSC_W];
      end else if (expire && (mode == ONESHOT)) begin
        en <= 1'b0;
      end

      // Prescaler is held at zero while disabled and restarts on LOAD writes.
      if (wr_load || !en || tick) psc_cnt <= '0;
      else                        psc_cnt <= psc_cnt + PSC_W'(1);

      if (wr_load) load <= wdata[CNT_W-1:0];

      // LOAD write wins over expiry/tick for COUNT; PEND is still set below.
      if (wr_load)     count <= wdata[CNT_W-1:0];
      else if (expire) count <= (mode == PERIODIC) ? load : '0;
      else if (tick)   count <= count - CNT_W'(1);

      // Expiry beats a same-cycle write-1-to-clear.
      if (expire)                    pend <= 1'b1;
      else if (wr_status && wdata[0]) pend <= 1'b0;
    end
  end

  always_comb begin
    ctrl_rd                              = '0;
    ctrl_rd[CTRL_EN_BIT]                 = en;
    ctrl_rd[CTRL_PERIODIC_BIT]           = (mode == PERIODIC);
    ctrl_rd[CTRL_IRQ_EN_BIT]             = irq_en;
    ctrl_rd[CTRL_PSC_LSB +: PSC_W]       = psc;
  end

  assign load_rd   = 32'(load);
  assign count_rd  = 32'(count);
  assign status_rd = {31'd0, pend};
  assign irq_req   = pend & irq_en;

endmodule

// File: rtl/avalon_multi_timer.sv
// Avalon-MM slave with N_CH independent down-counting timers.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   read_n, write_n : active-low Avalon strobes (write wins when both low)
//   address         : byte address, [3:2] register index, [7:4] channel
//   writeData       : write data
//   readData        : registered read data, valid one cycle after read_n=0
//   irq             : registered OR of PEND & IRQ_EN over all channels
module avalon_multi_timer
  import avalon_timer_pkg::*;
#(
  parameter int N_CH  = 4,
  parameter int CNT_W = 32,
  parameter int PSC_W = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        read_n,
  input  logic        write_n,
  input  logic [31:0] address,
  input  logic [31:0] writeData,
  output logic [31:0] readData,
  output logic        irq
);

  logic [CH_BITS-1:0] ch_sel;
  logic [1:0]         reg_idx;
  logic               wr;
  logic               rd;
  logic [31:0]        ctrl_rd   [N_CH];
  logic [31:0]        load_rd   [N_CH];
  logic [31:0]        count_rd  [N_CH];
  logic [31:0]        status_rd [N_CH];
  logic [N_CH-1:0]    irq_req;
  logic [31:0]        rd_mux;
  logic               unused_addr;

  assign ch_sel      = address[CH_BITS+3:4];
  assign reg_idx     = address[3:2];
  assign wr          = !write_n;
  assign rd          = !read_n && write_n;
  assign unused_addr = ^address;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    logic hit;
    assign hit = wr && (ch_sel == CH_BITS'(g));

    timer_channel #(
      .CNT_W (CNT_W),
      .PSC_W (PSC_W)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .wr_ctrl   (hit && (reg_idx == REG_CTRL)),
      .wr_load   (hit && (reg_idx == REG_LOAD)),
      .wr_status (hit && (reg_idx == REG_STATUS)),
      .wdata     (writeData),
      .ctrl_rd   (ctrl_rd[g]),
      .load_rd   (load_rd[g]),
      .count_rd  (count_rd[g]),
      .status_rd (status_rd[g]),
      .irq_req   (irq_req[g])
    );
  end

  // Unmapped channels fall through with zero.
  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (ch_sel == CH_BITS'(i)) begin
        case (reg_idx)
          REG_CTRL:  rd_mux = ctrl_rd[i];
          REG_LOAD:  rd_mux = load_rd[i];
          REG_COUNT: rd_mux = count_rd[i];
          default:   rd_mux = status_rd[i];
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      readData <= '0;
      irq      <= 1'b0;
    end else begin
      if (rd) readData <= rd_mux;
      irq <= |irq_req;
    end
  end

endmodule

// File: doc/avalon_multi_timer.md
AVALON_MULTI_TIMER -- requirements
Module: avalon_multi_timer

Interface
REQ-001 SHALL have parameter N_CH, default 4, number of timer channels (legal range 1..16).
REQ-002 SHALL have parameter CNT_W, default 32, counter width (legal range 8..32).
REQ-003 SHALL have parameter PSC_W, default 8, prescaler width (legal range 1..8).
REQ-004 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst, input, 1, reset, asynchronous and active-high.
REQ-006 SHALL have port read_n, input, 1, Avalon read strobe, active-low.
REQ-007 SHALL have port write_n, input, 1, Avalon write strobe, active-low.
REQ-008 SHALL have port address, input, 32, byte address; address[3:2] is the register index and address[CH_BITS+3:4] is the channel.
REQ-009 SHALL have port writeData, input, 32, write data.
REQ-010 SHALL have port readData, output, 32, registered read data.
REQ-011 SHALL have port irq, output, 1, level interrupt.

Function
REQ-012 SHALL provide four registers per channel:
- index 0, CTRL (RW): bit0 EN, bit1 PERIODIC, bit2 IRQ_EN, bits[8+PSC_W-1:8] PSC.
- index 1, LOAD (RW).
- index 2, COUNT (RO).
- index 3, STATUS (bit0 PEND, write-1-to-clear).
REQ-013 SHALL give readData a fixed latency of 1: data is valid the cycle after read_n=0 and holds until the next read.
REQ-014 SHALL return 0 for reads of unmapped channels (channel >= N_CH) and ignore writes to them; the output never floats.
REQ-015 SHALL ignore writeData bits above CNT_W on LOAD and zero-extend COUNT and LOAD on read.
REQ-016 SHALL treat read_n=0 and write_n=0 in the same cycle as a write only; readData holds its previous value.
REQ-017 SHALL, on a LOAD write, copy the value into COUNT and clear that channel's prescaler in the same cycle.
REQ-018 SHALL, while EN=1, run a per-channel prescaler that issues one tick every PSC+1 clk cycles; PSC=0 ticks every cycle.
REQ-019 SHALL, on a tick with COUNT>0, decrement COUNT by 1.
REQ-020 SHALL treat a tick with COUNT==0 as an expiry: set PEND; if PERIODIC=1, reload COUNT from LOAD; else clear EN and hold COUNT at 0.
REQ-021 SHALL, with LOAD=0 and PERIODIC=1, expire on every tick.
REQ-022 SHALL give an expiry priority over a same-cycle STATUS W1C, so PEND stays 1.
REQ-023 SHALL, when a same-cycle LOAD write and expiry occur, let the LOAD write set COUNT and still set PEND.
REQ-024 SHALL, on clearing EN, freeze COUNT and reset the prescaler; setting EN again resumes from the frozen COUNT.
REQ-025 SHALL drive irq as the registered OR over all channels of (PEND & IRQ_EN), so irq rises 1 cycle after PEND.
REQ-026 SHALL keep channels fully independent apart from the shared bus and irq.

Reset
REQ-027 SHALL, while rst=1, asynchronously clear every CTRL, LOAD, COUNT, PEND and prescaler, and drive readData=0 and irq=0.
REQ-028 SHALL, on reset asserted mid-count or mid-read, discard all state; no tick or expiry occurs in the first cycle after rst deasserts.

Structure
REQ-029 SHALL place the register index constants, CTRL bit positions and a mode enum (ONESHOT, PERIODIC) in the shared package avalon_timer_pkg.
REQ-030 SHALL implement each channel (prescaler, counter, CTRL, LOAD, PEND) as the sub-module timer_channel, instantiated N_CH times with generate; the top holds only address decode, the read mux and irq.

Verification
REQ-031 SHALL cover one-shot: ch0 LOAD=3, CTRL=EN|IRQ_EN with PSC=0 -> PEND set and irq=1 five cycles after enable; EN reads back 0; COUNT=0.
REQ-032 SHALL cover periodic with prescaler: ch2 LOAD=1, PSC=3, PERIODIC -> PEND every 8 cycles; after a W1C clears it, PEND sets again 8 cycles later.
REQ-033 SHALL cover W1C collision: a STATUS write of 1 in the exact expiry cycle -> PEND stays 1 and irq stays 1.
REQ-034 SHALL cover masking and OR: ch1 and ch3 expire with IRQ_EN only on ch3 -> irq=1; clearing ch3 PEND -> irq=0 while ch1 PEND reads 1.
REQ-035 SHALL cover width and unmapped access: CNT_W=16, write LOAD=0x0012_3456 -> reads 0x3456; with N_CH=2, a read of channel 3 returns 0.
REQ-036 SHALL cover reset mid-count: assert rst with COUNT=100 -> all registers read 0 and irq=0 on the next read.
